// File: rtl/rr_grant_encoder_pkg.sv
// Shared sizing and state encoding for the round-robin grant encoder.
// Imported by the priority encoder and the top-level arbiter.
package rr_grant_encoder_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : rr_grant_encoder_pkg

// File: rtl/rr_prio_encoder.sv
// Combinational round-robin priority search that starts at ptr and wraps N-1 -> 0.
// It rotates the requests so that ptr lands on bit 0, then does an LSB-first encode.
module rr_prio_encoder
    import rr_grant_encoder_pkg::*;
#(
    parameter int P_N    = N,
    parameter int P_IDXW = IDXW
) (
    input  logic [P_N-1:0]    req,
    input  logic [P_IDXW-1:0] ptr,
    output logic [P_IDXW-1:0] idx,
    output logic              any
);

    logic [2*P_N-1:0]  req_doubled;
    logic [P_N-1:0]    req_rotated;
    logic [P_IDXW-1:0] offset;

    // Doubling the vector turns the rotate-right into a plain variable part-select.
    assign req_doubled = {req, req};
    assign req_rotated = req_doubled[ptr +: P_N];

    always_comb begin
        offset = '0;
        for (int i = P_N - 1; i >= 0; i--) begin
            if (req_rotated[i]) begin
                offset = P_IDXW'(i);
            end
        end
    end

    // P_N is a power of two, so the IDXW-bit add wraps back to the true index.
    assign idx = ptr + offset;
    assign any = |req;

endmodule : rr_prio_encoder

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter producing a registered binary grant index held until acknowledged.
// Shares one register-file write port between several producers.
module rr_grant_encoder
    import rr_grant_encoder_pkg::*;
#(
    parameter int P_N    = N,
    parameter int P_IDXW = IDXW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              En,
    input  logic [P_N-1:0]    req,
    output logic [P_IDXW-1:0] grant_idx,
    output logic [P_N-1:0]    grant_onehot,
    output logic              grant_vld,
    input  logic              grant_ack
);

    state_t            state_q, state_d;
    logic [P_IDXW-1:0] ptr_q, ptr_d;
    logic [P_IDXW-1:0] idx_d;
    logic [P_N-1:0]    onehot_d;
    logic              vld_d;
    logic [P_IDXW-1:0] enc_idx;
    logic              enc_any;

    rr_prio_encoder #(
        .P_N    (P_N),
        .P_IDXW (P_IDXW)
    ) u_prio (
        .req (req),
        .ptr (ptr_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = grant_idx;
        onehot_d = grant_onehot;
        vld_d    = grant_vld;
        case (state_q)
            IDLE: begin
                if (En && enc_any) begin
                    idx_d    = enc_idx;
                    onehot_d = {{(P_N-1){1'b0}}, 1'b1} << enc_idx;
                    vld_d    = 1'b1;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                // Returning to IDLE forces one bubble cycle before the next grant.
                if (grant_ack) begin
                    ptr_d    = grant_idx + P_IDXW'(1);
                    onehot_d = '0;
                    vld_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
                vld_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            grant_vld    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_idx    <= idx_d;
            grant_onehot <= onehot_d;
            grant_vld    <= vld_d;
        end
    end

endmodule : rr_grant_encoder

// File: tb/tb_rr_grant_encoder.sv
// Self-checking bench for rr_grant_encoder: vector table plus hand-written
// sequences for reset, fairness, hold, pointer wrap and asynchronous reset.
module tb_rr_grant_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       En;
    logic [7:0] req;
    logic [2:0] grant_idx;
    logic [7:0] grant_onehot;
    logic       grant_vld;
    logic       grant_ack;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] oh;
        logic       vld;
        string      name;
    } exp_t;

    typedef struct {
        logic [7:0] req;
        logic       en;
        logic       ack;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       vld;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    rr_grant_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .En           (En),
        .req          (req),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .grant_vld    (grant_vld),
        .grant_ack    (grant_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushExpected(input logic [2:0] xi, input logic [7:0] xo,
                                input logic xv, input string nm);
        exp_t e;
        e.idx  = xi;
        e.oh   = xo;
        e.vld  = xv;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: actual=empty required=entry");
            return;
        end
        e = sb.pop_front();
        compared++;
        if (grant_idx !== e.idx) begin
            mismatched++;
            $display("[TB] FAIL %s idx: actual=%0d required=%0d @%0t", e.name, grant_idx, e.idx, $time);
        end
        compared++;
        if (grant_onehot !== e.oh) begin
            mismatched++;
            $display("[TB] FAIL %s onehot: actual=%h required=%h @%0t", e.name, grant_onehot, e.oh, $time);
        end
        compared++;
        if (grant_vld !== e.vld) begin
            mismatched++;
            $display("[TB] FAIL %s vld: actual=%b required=%b @%0t", e.name, grant_vld, e.vld, $time);
        end
    endtask

    // Drives one cycle of inputs, records what the next edge must produce, then samples 1ns after it.
    task automatic applyStimulus(input logic [7:0] r, input logic e, input logic a,
                                 input logic [2:0] xi, input logic [7:0] xo,
                                 input logic xv, input string nm);
        req       = r;
        En        = e;
        grant_ack = a;
        pushExpected(xi, xo, xv, nm);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 8'hFF;
        En        = 1'b1;
        grant_ack = 1'b0;

        // Reset asserted with every requester active: nothing may be granted.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, "reset_hold");
        end
        rst_n = 1'b1;

        vecs[0] = '{req: 8'h04, en: 1'b1, ack: 1'b0, idx: 3'd2, oh: 8'h04, vld: 1'b1};
        vecs[1] = '{req: 8'h00, en: 1'b1, ack: 1'b1, idx: 3'd2, oh: 8'h00, vld: 1'b0};
        vecs[2] = '{req: 8'h09, en: 1'b0, ack: 1'b0, idx: 3'd2, oh: 8'h00, vld: 1'b0};
        vecs[3] = '{req: 8'h09, en: 1'b1, ack: 1'b0, idx: 3'd3, oh: 8'h08, vld: 1'b1};
        vecs[4] = '{req: 8'h00, en: 1'b0, ack: 1'b0, idx: 3'd3, oh: 8'h08, vld: 1'b1};
        vecs[5] = '{req: 8'h00, en: 1'b0, ack: 1'b1, idx: 3'd3, oh: 8'h00, vld: 1'b0};
        vecs[6] = '{req: 8'h09, en: 1'b1, ack: 1'b1, idx: 3'd0, oh: 8'h01, vld: 1'b1};
        vecs[7] = '{req: 8'hFF, en: 1'b1, ack: 1'b1, idx: 3'd0, oh: 8'h00, vld: 1'b0};
        vecs[8] = '{req: 8'hFF, en: 1'b1, ack: 1'b0, idx: 3'd1, oh: 8'h02, vld: 1'b1};
        vecs[9] = '{req: 8'hFF, en: 1'b1, ack: 1'b1, idx: 3'd1, oh: 8'h00, vld: 1'b0};
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].req, vecs[v].en, vecs[v].ack,
                          vecs[v].idx, vecs[v].oh, vecs[v].vld, $sformatf("vec%0d", v));
        end

        // Fresh pointer, then every requester active: strict rotation with a bubble between grants.
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(8'hFF, 1'b1, 1'b0, 3'(k % 8), 8'h01 << (k % 8), 1'b1,
                          $sformatf("fair_grant%0d", k));
            applyStimulus(8'hFF, 1'b1, 1'b1, 3'(k % 8), 8'h00, 1'b0,
                          $sformatf("fair_bubble%0d", k));
        end

        // Pointer is now 1; grant 5 and hold it while req and En move underneath.
        applyStimulus(8'h20, 1'b1, 1'b0, 3'd5, 8'h20, 1'b1, "hold_issue");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(8'h01, 1'b0, 1'b0, 3'd5, 8'h20, 1'b1, $sformatf("hold%0d", k));
        end
        applyStimulus(8'h01, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0, "hold_ack");

        // Pointer 6: search 6,7,0 picks 0; then pointer 1 picks 3.
        applyStimulus(8'h09, 1'b1, 1'b0, 3'd0, 8'h01, 1'b1, "skip_wrap");
        applyStimulus(8'h09, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, "skip_wrap_ack");
        applyStimulus(8'h09, 1'b1, 1'b0, 3'd3, 8'h08, 1'b1, "skip_fwd");
        applyStimulus(8'h09, 1'b1, 1'b1, 3'd3, 8'h00, 1'b0, "skip_fwd_ack");

        // Pointer 4: grant 4, then pulse reset between edges.
        applyStimulus(8'h10, 1'b1, 1'b0, 3'd4, 8'h10, 1'b1, "areset_setup");
        #2;
        rst_n = 1'b0;
        #1;
        pushExpected(3'd0, 8'h00, 1'b0, "areset_immediate");
        checkOutput();
        rst_n = 1'b1;
        applyStimulus(8'h30, 1'b1, 1'b0, 3'd4, 8'h10, 1'b1, "areset_ptr0");

        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_leftover: actual=%0d required=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_rr_grant_encoder
